// File: rtl/had_transform_source_if.sv
// had_transform_source_if -- sample/coefficient bus for had_transform_source.
//   din        : 4-bit unsigned sample (master -> slave)
//   wen        : write strobe, one sample per rising transition (master -> slave)
//   ready      : slave accepts samples (slave -> master)
//   dout       : 9-bit signed transform coefficient (slave -> master)
//   dout_valid : dout carries a coefficient this cycle (slave -> master)
//   done       : pulse coincident with the last coefficient (slave -> master)
interface had_transform_source_if;
  logic [3:0] din;
  logic       wen;
  logic       ready;
  logic [8:0] dout;
  logic       dout_valid;
  logic       done;

  modport master (
    output din, wen,
    input  ready, dout, dout_valid, done
  );

  modport slave (
    input  din, wen,
    output ready, dout, dout_valid, done
  );
endinterface

// File: rtl/had_transform_source.sv
// had_transform_source -- 16-point unnormalized Walsh-Hadamard transform.
// Collects 16 unsigned 4-bit samples (one per rising edge of wen), runs four
// in-place butterfly stages (one per cycle) and streams X[0]..X[15] in
// natural Hadamard order as 9-bit signed coefficients.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous reset, ACTIVE-HIGH despite the name
//   bus   : slave side of had_transform_source_if (din, wen, ready, dout,
//           dout_valid, done)
module had_transform_source (
  input  logic                          clk,
  input  logic                          rst_n,
  had_transform_source_if.slave         bus
);

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    XFORM = 2'd1,
    OUT   = 2'd2
  } state_t;

  state_t            state_q;
  logic [3:0]        wr_cnt_q;
  logic              wen_q;
  logic signed [8:0] x_q [16];
  logic [1:0]        stage_q;
  logic [4:0]        oidx_q;
  logic [8:0]        dout_q;
  logic              dout_valid_q;
  logic              done_q;
  logic              ready_q;

  logic              write_det;
  logic signed [8:0] xbf_d [16];
  logic [3:0]        span;
  logic [3:0]        idx;

  assign write_det      = bus.wen & ~wen_q;
  assign bus.ready      = ready_q;
  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.done       = done_q;

  // One butterfly stage: element i pairs with i ^ 2^s; the lower index of a
  // pair takes the sum, the upper index takes (lower - upper).
  always_comb begin
    span = 4'b0001 << stage_q;
    idx  = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      idx = 4'(i);
      if (idx[stage_q] == 1'b0) begin
        xbf_d[i] = x_q[i] + x_q[idx | span];
      end else begin
        xbf_d[i] = x_q[idx ^ span] - x_q[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q      <= LOAD;
      wr_cnt_q     <= '0;
      wen_q        <= 1'b0;
      for (int unsigned i = 0; i < 16; i++) begin
        x_q[i] <= '0;
      end
      stage_q      <= '0;
      oidx_q       <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      done_q       <= 1'b0;
      ready_q      <= 1'b1;
    end else begin
      wen_q <= bus.wen;
      case (state_q)
        LOAD: begin
          if (write_det) begin
            x_q[wr_cnt_q] <= $signed({5'b0, bus.din});
            wr_cnt_q      <= wr_cnt_q + 4'd1;
            if (wr_cnt_q == 4'd15) begin
              state_q <= XFORM;
              stage_q <= '0;
              ready_q <= 1'b0;
            end
          end
        end
        XFORM: begin
          for (int unsigned i = 0; i < 16; i++) begin
            x_q[i] <= xbf_d[i];
          end
          stage_q <= stage_q + 2'd1;
          if (stage_q == 2'd3) begin
            state_q <= OUT;
            oidx_q  <= '0;
          end
        end
        OUT: begin
          // Outputs are registered, so OUT spans 17 cycles: 16 that load a
          // coefficient and one that clears the outputs and returns to LOAD.
          if (oidx_q == 5'd16) begin
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            done_q       <= 1'b0;
            state_q      <= LOAD;
            ready_q      <= 1'b1;
          end else begin
            dout_q       <= x_q[oidx_q[3:0]];
            dout_valid_q <= 1'b1;
            done_q       <= (oidx_q == 5'd15);
            oidx_q       <= oidx_q + 5'd1;
          end
        end
        default: begin
          state_q <= LOAD;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_had_transform_source.sv
// tb_had_transform_source -- directed, table-driven bench for
// had_transform_source with hand-computed Walsh-Hadamard results.
module tb_had_transform_source;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  had_transform_source_if bus ();

  had_transform_source dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;
  int unsigned last_store = 0;

  typedef struct {
    string      name;
    logic [3:0] din  [16];
    bit         vary;
    int         expv [16];
  } vec_t;

  vec_t        vt [5];
  int unsigned wtab [5] = '{1, 2, 5, 7, 9};

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Single write of d with wen held for w edges; caller leaves wen low
  // at the preceding edge.
  task automatic wr(input logic [3:0] d, input int unsigned w);
    bus.din = d;
    bus.wen = 1'b1;
    @(posedge clk); #1;
    last_store = cyc;
    for (int unsigned k = 1; k < w; k++) begin
      @(posedge clk); #1;
    end
    bus.wen = 1'b0;
    @(posedge clk); #1;
  endtask

  // Waits for the output burst and compares it; returns at the negedge of
  // the first cycle back in LOAD.
  task automatic collect(input int v, input bit noise);
    int waited;
    waited = 0;
    @(negedge clk);
    while (bus.dout_valid !== 1'b1 && waited < 20) begin
      chk({vt[v].name, ".ready_busy"}, int'(bus.ready), 0);
      if (noise) begin
        bus.din = 4'd7;
        bus.wen = ~bus.wen;
      end
      waited++;
      @(negedge clk);
    end
    if (bus.dout_valid !== 1'b1) begin
      chk({vt[v].name, ".timeout"}, 0, 1);
      bus.wen = 1'b0;
      return;
    end
    chk({vt[v].name, ".latency"}, int'(cyc - last_store), 5);
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("%s.X%0d", vt[v].name, k), int'($signed(bus.dout)), vt[v].expv[k]);
      chk($sformatf("%s.valid%0d", vt[v].name, k), int'(bus.dout_valid), 1);
      chk($sformatf("%s.done%0d", vt[v].name, k), int'(bus.done), (k == 15) ? 1 : 0);
      chk($sformatf("%s.ready%0d", vt[v].name, k), int'(bus.ready), 0);
      if (noise) begin
        bus.din = 4'd9;
        bus.wen = (k < 15) ? ~bus.wen : 1'b0;
      end
      @(negedge clk);
    end
    chk({vt[v].name, ".valid_after"}, int'(bus.dout_valid), 0);
    chk({vt[v].name, ".dout_after"}, int'(bus.dout), 0);
    chk({vt[v].name, ".done_after"}, int'(bus.done), 0);
    chk({vt[v].name, ".ready_after"}, int'(bus.ready), 1);
  endtask

  task automatic run_vec(input int v, input bit noise);
    int unsigned w;
    for (int n = 0; n < 16; n++) begin
      w = (n == 15) ? 1 : (vt[v].vary ? wtab[n % 5] : 1);
      wr(vt[v].din[n], w);
    end
    collect(v, noise);
  endtask

  initial begin
    int got;

    // constant 12: only the DC term survives
    vt[0].name = "const12";
    vt[0].vary = 1'b1;
    for (int n = 0; n < 16; n++) begin
      vt[0].din[n]  = 4'd12;
      vt[0].expv[n] = (n == 0) ? 192 : 0;
    end
    // ramp 0..15
    vt[1].name = "ramp";
    vt[1].vary = 1'b0;
    for (int n = 0; n < 16; n++) begin
      vt[1].din[n]  = 4'(n);
      vt[1].expv[n] = 0;
    end
    vt[1].expv[0] = 120;
    vt[1].expv[1] = -8;
    vt[1].expv[2] = -16;
    vt[1].expv[4] = -32;
    vt[1].expv[8] = -64;
    // impulse at n=0: flat spectrum
    vt[2].name = "impulse";
    vt[2].vary = 1'b0;
    for (int n = 0; n < 16; n++) begin
      vt[2].din[n]  = (n == 0) ? 4'd15 : 4'd0;
      vt[2].expv[n] = 15;
    end
    // alternating 15,0
    vt[3].name = "alt";
    vt[3].vary = 1'b1;
    for (int n = 0; n < 16; n++) begin
      vt[3].din[n]  = (n % 2 == 0) ? 4'd15 : 4'd0;
      vt[3].expv[n] = (n < 2) ? 120 : 0;
    end
    // impulse at n=3: sign pattern +,-,-,+ repeating
    vt[4].name = "imp3";
    vt[4].vary = 1'b0;
    for (int n = 0; n < 16; n++) begin
      vt[4].din[n]  = (n == 3) ? 4'd1 : 4'd0;
      vt[4].expv[n] = ((n % 4 == 0) || (n % 4 == 3)) ? 1 : -1;
    end

    rst_n   = 1'b1;
    bus.din = '0;
    bus.wen = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst.ready", int'(bus.ready), 1);
    chk("rst.valid", int'(bus.dout_valid), 0);
    chk("rst.dout", int'(bus.dout), 0);
    chk("rst.done", int'(bus.done), 0);
    rst_n = 1'b0;
    @(posedge clk); #1;

    run_vec(0, 1'b0);
    run_vec(1, 1'b0);
    run_vec(2, 1'b0);
    run_vec(3, 1'b1);   // stray writes during XFORM/OUT
    run_vec(4, 1'b0);   // must be unaffected by the noise above

    // reset after 9 writes, released with wen already high
    for (int n = 0; n < 9; n++) wr(4'd5, 2);
    rst_n = 1'b1;
    #1;
    chk("midrst.ready", int'(bus.ready), 1);
    chk("midrst.valid", int'(bus.dout_valid), 0);
    chk("midrst.dout", int'(bus.dout), 0);
    bus.din = 4'd12;
    bus.wen = 1'b1;
    #1 rst_n = 1'b0;
    for (int n = 0; n < 16; n++) wr(4'd12, 1);
    collect(0, 1'b0);

    // reset during XFORM must abort the block
    for (int n = 0; n < 16; n++) wr(4'd12, 1);
    #1 rst_n = 1'b1;
    #1 chk("xfrst.ready", int'(bus.ready), 1);
    #1 rst_n = 1'b0;
    got = 0;
    repeat (25) begin
      @(negedge clk);
      if (bus.dout_valid === 1'b1) got = 1;
    end
    chk("xfrst.no_output", got, 0);

    run_vec(1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
